// File: rtl/chan_mux_pkg.sv
// Shared constants and types for the registered round-robin channel selector.
package chan_mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Output slot occupancy: EMPTY means out_valid is low.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Wrapped-priority search: first set req bit after ptr, wrapping at N-1 -> 0,
// with ptr itself checked last. Purely combinational.
module rr_pick #(
    parameter int N = 16
) (
    input  logic [N-1:0]           req,
    input  logic [$clog2(N)-1:0]   ptr,
    output logic [$clog2(N)-1:0]   gnt_idx,
    output logic                   any
);

    localparam int PW = $clog2(N);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_idx = '0;
        any     = |req;
        sum     = '0;
        idx     = '0;
        for (int i = N; i >= 1; i--) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N))
                sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (req[idx])
                gnt_idx = idx;
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// Registered N-channel selector with direct and round-robin scan modes,
// valid/ready output handshake and per-channel one-hot capture acknowledge.
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ack,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_load,
    output logic                      sel_err,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Flattened bus has channel k at [k*WIDTH +: WIDTH], identical to a packed array.
    logic [CHANNELS-1:0][WIDTH-1:0] words;
    assign words = in_data;

    state_t          state, state_nxt;
    logic [SEL_W-1:0] cur_sel, rr_ptr, scan_idx, cand;
    logic             scan_any, free, cap, sel_bad;

    rr_pick #(.N(CHANNELS)) u_pick (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (scan_idx),
        .any     (scan_any)
    );

    assign out_valid = (state == ST_FULL);
    assign free      = !out_valid || out_ready;
    assign sel_bad   = ({1'b0, sel} >= (SEL_W+1)'(CHANNELS));

    // Candidate channel and capture decision; uses the current (old) cur_sel.
    always_comb begin
        cand = cur_sel;
        cap  = 1'b0;
        if (mode == MODE_SCAN) begin
            cand = scan_idx;
            cap  = free && scan_any;
        end else begin
            cap  = free && in_valid[cur_sel];
        end
    end

    // Acknowledge the captured channel in the same cycle; silent during reset.
    always_comb begin
        in_ack = '0;
        if (rst_n && cap)
            in_ack[cand] = 1'b1;
    end

    // Next-state logic for output slot occupancy.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (cap)                 state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !cap)   state_nxt = ST_EMPTY;
            default:                           state_nxt = ST_EMPTY;
        endcase
    end

    // Slot occupancy register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Select register; out-of-range loads are rejected and flagged for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_sel <= '0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= sel_load && sel_bad;
            if (sel_load && !sel_bad)
                cur_sel <= sel;
        end
    end

    // Scan pointer; starts at the last channel so the first scan begins at 0.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr <= SEL_W'(CHANNELS - 1);
        else if (cap && mode == MODE_SCAN)
            rr_ptr <= cand;
    end

    // Output word register; only loads on capture, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_chan <= '0;
        end else if (cap) begin
            out_data <= words[cand];
            out_chan <= cand;
        end
    end

endmodule

// File: doc/chan_mux_rr.md
# chan_mux_rr

Parametrised, registered N-channel selector: successor to the combinational 16:1 nibble multiplexer. Routes one of CHANNELS input words to a single registered output with a valid/ready handshake. Supports a direct mode (programmed select) and a round-robin scan mode that cycles through channels with pending data. Invalid selects raise an error flag instead of a simulation-only message. Sits between the per-channel sources and a single downstream consumer.

## Interface
Parameters:
- WIDTH, 4, bits per channel word
- CHANNELS, 16, number of input channels, ≥2, need not be a power of two
- SEL_W, $clog2(CHANNELS), select width (derived; not overridden)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_data  in  CHANNELS*WIDTH  flattened inputs; channel k at [k*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel data present
- in_ack  out  CHANNELS  one-hot; channel k word captured this cycle
- mode  in  1  0 = direct, 1 = scan; sampled every cycle
- sel  in  SEL_W  requested channel, direct mode
- sel_load  in  1  load sel into select register
- sel_err  out  1  one-cycle pulse: sel_load with sel ≥ CHANNELS
- out_data  out  WIDTH  registered selected word
- out_chan  out  SEL_W  channel index of out_data
- out_valid  out  1  out_data holds an unaccepted word
- out_ready  in  1  consumer accepts when out_valid & out_ready

## Operation
- Select register cur_sel: on sel_load, if sel < CHANNELS then cur_sel <= sel, else cur_sel unchanged and sel_err = 1 next cycle. The new cur_sel takes effect from the following cycle.
- Slot free: free = !out_valid | out_ready.
- Direct mode: candidate = cur_sel. Scan mode: candidate = first k with in_valid[k], searching rr_ptr+1, rr_ptr+2, … wrapping at CHANNELS-1 → 0, including rr_ptr last.
- Capture when free and in_valid[candidate] (scan: any in_valid set): out_data <= word, out_chan <= candidate, out_valid <= 1, in_ack[candidate] = 1 (combinational, same cycle). Scan mode also updates rr_ptr <= candidate; direct mode leaves rr_ptr unchanged.
- free with no capture: out_valid <= 0.
- !free: out_data, out_chan, out_valid held. in_ack = 0.
- FSM (2 states): EMPTY (out_valid=0) → FULL on capture. FULL → FULL on accept+capture or on stall. FULL → EMPTY on accept without capture.
- Mode change while FULL: held word is unaffected; the new mode applies to the next capture.

## Timing
- Reset values: out_data 0, out_chan 0, out_valid 0, sel_err 0, in_ack 0, cur_sel 0, rr_ptr CHANNELS-1 (first scan starts at channel 0), FSM EMPTY.
- Latency: in_valid sampled at edge n → out_valid at n+1.
- Throughput: one word per cycle with out_ready held high.
- No combinational path from out_ready to out_data. in_ack depends on out_ready, in_valid, mode and cur_sel.
- Reset mid-transfer: held word discarded; no in_ack during reset.
- sel_load and capture in the same cycle: capture uses the old cur_sel.

## Structure
- Package chan_mux_pkg: mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1; FSM state enum {ST_EMPTY, ST_FULL}.
- Sub-module rr_pick (parameter N): inputs req[N], ptr; outputs gnt_idx, any. Purely combinational wrapped-priority search, reusable by other arbiters.
- Top level holds the select register, rr_ptr, output register and FSM.

## Test plan
- Direct mode, defaults: sel_load sel=5. in_valid[5]=1, ch5=4'hA, out_ready=1 → out_data=A, out_chan=5, out_valid=1 one cycle after sampling; in_ack[5] pulses.
- Backpressure: out_ready=0 for 3 cycles with ch5 data changing → out_data held at A, in_ack=0. Raise ready → next word captured the same cycle.
- Scan mode: in_valid=16'h8421 constant, out_ready=1 → out_chan sequence 0,5,10,15,0, each with the matching in_ack.
- Error: CHANNELS=10, sel_load sel=12 → sel_err=1 for one cycle, cur_sel keeps its prior value 3, and output continues from ch3.
- Reset mid-operation: rst_n=0 while out_valid=1 → next cycle out_valid=0, out_data=0, out_chan=0. After release, scan starts at channel 0.
- Mode switch while stalled FULL: held ch5 word retained. After accept, the next capture follows scan order from rr_ptr.
